// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: assembles a 32-bit little-endian instruction
// from four single-byte memory reads, with branch flush and decode back-pressure.
module inst_fetch #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  input  logic        flush_i,
  input  logic        id_stall_i,
  input  logic        mem_busy_i,
  input  logic [7:0]  mem_rdata_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o,
  output logic        stallreq_o
);

  localparam logic [1:0] LAT = 2'(MEM_LAT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc;
  logic [1:0]  k;
  logic [1:0]  cnt;
  logic [23:0] lo_bytes;
  logic        start, accept, lat_done, sample;

  assign accept   = (state == REQ) && !mem_busy_i;
  assign lat_done = (cnt == LAT);
  assign sample   = (state == WAIT) && lat_done && !flush_i;

  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      IDLE: if (ce_i && !flush_i) begin
        start   = 1'b1;
        state_n = REQ;
      end
      // An accepted request cannot be recalled, so a same-edge flush must drain it.
      REQ: begin
        if (accept)       state_n = flush_i ? DRAIN : WAIT;
        else if (flush_i) state_n = IDLE;
      end
      WAIT: begin
        if (flush_i)       state_n = DRAIN;
        else if (lat_done) state_n = (k == 2'd3) ? DONE : REQ;
      end
      DRAIN: if (lat_done) state_n = IDLE;
      DONE: begin
        if (flush_i) state_n = IDLE;
        else if (!id_stall_i) begin
          if (ce_i) begin
            start   = 1'b1;
            state_n = REQ;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= '0;
      k         <= '0;
      cnt       <= '0;
      lo_bytes  <= '0;
      if_pc_o   <= '0;
      if_inst_o <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        fetch_pc <= pc_i;
        k        <= '0;
      end
      // cnt holds the number of edges since acceptance; it saturates at LAT.
      if (accept)
        cnt <= 2'd1;
      else if ((state == WAIT || state == DRAIN) && !lat_done)
        cnt <= cnt + 2'd1;
      if (sample) begin
        case (k)
          2'd0: lo_bytes[7:0]   <= mem_rdata_i;
          2'd1: lo_bytes[15:8]  <= mem_rdata_i;
          2'd2: lo_bytes[23:16] <= mem_rdata_i;
          default: begin
            if_inst_o <= {mem_rdata_i, lo_bytes};
            if_pc_o   <= fetch_pc;
          end
        endcase
        if (k != 2'd3) k <= k + 2'd1;
      end
    end
  end

  assign mem_req_o  = (state == REQ);
  assign mem_addr_o = fetch_pc + {30'd0, k};
  assign if_valid_o = (state == DONE);
  assign stallreq_o = (state == REQ) || (state == WAIT) || (state == DRAIN);

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: two instances (MEM_LAT=1 and 3) driven by
// directed and random stimulus, checked against a fetch-level reference model.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0][31:0] pc    = '0;
  logic [1:0]       ce    = '0;
  logic [1:0]       flush = '0;
  logic [1:0]       stall = '0;
  logic [1:0]       busy  = '0;
  logic [1:0]       mreq, ifvalid, sreq;
  logic [1:0][31:0] maddr, ifpc, ifinst;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic end_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          due;
  } exp_t;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:       mem_byte = 8'h13;
      32'd1:       mem_byte = 8'h05;
      32'd2, 32'd3: mem_byte = 8'h00;
      default:     mem_byte = 8'(a[7:0] * 8'd37) ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] inst_at(input logic [31:0] p);
    inst_at = {mem_byte(p + 32'd3), mem_byte(p + 32'd2), mem_byte(p + 32'd1), mem_byte(p)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int L = (g == 0) ? 1 : 3;
    logic [7:0]  rd;
    int          age   = 0;
    logic [31:0] aaddr = '0;
    logic        rst_q = 1'b0;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          busy_cnt = 0;
    bit          seen = 0;

    inst_fetch #(.MEM_LAT(L)) u_dut (
      .clk(clk), .rst(rst), .pc_i(pc[g]), .ce_i(ce[g]), .flush_i(flush[g]),
      .id_stall_i(stall[g]), .mem_busy_i(busy[g]), .mem_rdata_i(rd),
      .mem_req_o(mreq[g]), .mem_addr_o(maddr[g]), .if_pc_o(ifpc[g]),
      .if_inst_o(ifinst[g]), .if_valid_o(ifvalid[g]), .stallreq_o(sreq[g])
    );

    // Memory: the byte is correct only in the cycle ending exactly L edges after acceptance.
    always @(posedge clk) begin
      rst_q <= rst;
      if (!rst && mreq[g] && !busy[g]) begin
        age   <= 1;
        aaddr <= maddr[g];
      end else if (age > 0 && age < 8) begin
        age <= age + 1;
      end
    end
    assign rd = (age == L) ? mem_byte(aaddr) : (mem_byte(aaddr) ^ 8'hA5);

    always @(negedge clk) begin
      if (rst_q) begin
        chk("rst_mem_req", 32'(mreq[g]), 0);
        chk("rst_mem_addr", maddr[g], 0);
        chk("rst_if_pc", ifpc[g], 0);
        chk("rst_if_inst", ifinst[g], 0);
        chk("rst_if_valid", 32'(ifvalid[g]), 0);
        chk("rst_stallreq", 32'(sreq[g]), 0);
      end
      if (rst) begin
        exp_q.delete();
        addr_q.delete();
        seen = 0;
      end else begin
        if (mreq[g]) begin
          if (addr_q.size() == 0) fail($sformatf("req_unexpected lane%0d addr %h", g, maddr[g]));
          else begin
            chk("req_addr", maddr[g], addr_q[0]);
            if (!busy[g]) void'(addr_q.pop_front());
            else busy_cnt++;
          end
        end
        if (addr_q.size() != 0) chk("stallreq_fetching", 32'(sreq[g]), 1);
        if (ifvalid[g]) begin
          chk("stallreq_done", 32'(sreq[g]), 0);
          if (exp_q.size() == 0) fail($sformatf("valid_unexpected lane%0d pc %h", g, ifpc[g]));
          else begin
            if (!seen) begin
              chk("latency", 32'(cyc), 32'(exp_q[0].due + busy_cnt));
              seen = 1;
            end
            chk("if_pc", ifpc[g], exp_q[0].pc);
            chk("if_inst", ifinst[g], exp_q[0].inst);
            if (!flush[g] && !stall[g]) begin
              void'(exp_q.pop_front());
              seen = 0;
            end
          end
        end
        if (flush[g]) begin
          exp_q.delete();
          addr_q.delete();
          seen = 0;
        end
        if (ce[g] && !flush[g] && !sreq[g] && !(ifvalid[g] && stall[g])) begin
          exp_q.push_back('{pc: pc[g], inst: inst_at(pc[g]), due: cyc + 1 + 4 * (L + 1)});
          for (int j = 0; j < 4; j++) addr_q.push_back(pc[g] + 32'(j));
          busy_cnt = 0;
        end
      end
      if (end_chk) chk("queue_empty", 32'(exp_q.size()), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [31:0] p);
    pc[i] = p;
    ce[i] = 1'b1;
    step();
    ce[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < 400; n++) begin
      if (!sreq[i] && !ifvalid[i]) return;
      step();
    end
    fail($sformatf("timeout_idle lane%0d", i));
  endtask

  task automatic rand_run(input int i);
    for (int n = 0; n < 400; n++) begin
      pc[i]    = ($urandom % 4 == 0) ? (32'hFFFFFFFC + ($urandom % 4)) : $urandom;
      ce[i]    = ($urandom % 3) != 0;
      flush[i] = ($urandom % 12) == 0;
      stall[i] = ($urandom % 4) == 0;
      busy[i]  = ($urandom % 4) == 0;
      step();
    end
    ce[i] = 0; flush[i] = 0; stall[i] = 0; busy[i] = 0;
    wait_idle(i);
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    step();

    // Basic fetch of 0x00000513 at address 0.
    issue(0, 32'h0);
    wait_idle(0);

    // Memory busy for three cycles while byte 2 is being requested.
    issue(0, 32'h40);
    repeat (4) step();
    busy[0] = 1'b1;
    repeat (3) step();
    busy[0] = 1'b0;
    wait_idle(0);

    // Decode stall holds the delivered instruction, then back-to-back fetch from 0x4.
    stall[0] = 1'b1;
    issue(0, 32'h80);
    for (int n = 0; n < 50 && !ifvalid[0]; n++) step();
    for (int n = 0; n < 5; n++) begin
      chk("stall_hold_valid", 32'(ifvalid[0]), 1);
      step();
    end
    stall[0] = 1'b0;
    issue(0, 32'h4);
    chk("next_req", 32'(mreq[0]), 1);
    chk("next_addr", maddr[0], 32'h4);
    wait_idle(0);

    // Address wrap past 2^32.
    issue(0, 32'hFFFFFFFE);
    wait_idle(0);

    // Reset while waiting on byte 2, then fetch immediately after reset.
    issue(0, 32'h200);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    issue(0, 32'h8);
    wait_idle(0);

    // MEM_LAT=3: flush while waiting on byte 1, drain, then refetch.
    issue(1, 32'h300);
    repeat (6) step();
    flush[1] = 1'b1;
    step();
    flush[1] = 1'b0;
    chk("drain_stallreq", 32'(sreq[1]), 1);
    chk("drain_no_req", 32'(mreq[1]), 0);
    wait_idle(1);
    issue(1, 32'h100);
    wait_idle(1);

    fork
      rand_run(0);
      rand_run(1);
    join

    end_chk = 1'b1;
    step();
    end_chk = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
